// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   state_t : controller states (IDLE, ITER, CORRECT, FINISH)
//   clog2   : ceiling log2, used to size the iteration counter
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  // Smallest r with 2**r >= value (value >= 2 in all uses here).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nr_addsub.sv
// Controlled add/subtract row: sum = sub ? a - b : a + b.
// Ports:
//   a, b : WIDTH-bit signed operands
//   sub  : 1 selects subtraction (b inverted, carry-in 1)
//   sum  : WIDTH-bit result, carry out of the MSB discarded
// This is the shared row that replaces the chain of CAS cells; the divider
// reuses it for every iteration and for the remainder-correction cycle.
module nr_addsub #(
  parameter int WIDTH = 9
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] sum
);

  logic signed [WIDTH-1:0] b_x;
  logic signed [WIDTH-1:0] cin;

  assign b_x = b ^ {WIDTH{sub}};
  assign cin = $signed({{(WIDTH-1){1'b0}}, sub});
  assign sum = a + b_x + cin;

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Iterative unsigned divider, non-restoring algorithm, one quotient bit per
// clock followed by one remainder-correction clock.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only while busy=0
//   dividend     : WIDTH-bit unsigned dividend (captured on acceptance)
//   divisor      : WIDTH-bit unsigned divisor (captured on acceptance)
//   busy         : high from the accepting edge until the edge raising done
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : WIDTH-bit quotient, all ones on divide-by-zero
//   remainder    : WIDTH-bit remainder, the dividend on divide-by-zero
//   div_by_zero  : set with done when the captured divisor was zero
module seq_nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int AW    = WIDTH + 1;
  localparam int CNT_W = clog2(WIDTH + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic                 dz_pend;

  // Datapath registers: partial remainder, quotient/dividend shifter, divisor.
  logic signed [AW-1:0] a_reg;
  logic [WIDTH-1:0]     q_reg;
  logic signed [AW-1:0] m_reg;

  logic signed [AW-1:0] shift_a;
  logic signed [AW-1:0] as_a;
  logic signed [AW-1:0] as_sum;
  logic                 as_sub;
  logic                 div_zero_in;

  assign div_zero_in = (divisor == '0);

  // Left shift of {A,Q}: the dividend MSB moves into A.
  assign shift_a = $signed({a_reg[AW-2:0], q_reg[WIDTH-1]});

  // In ITER the row subtracts when the old A is non-negative and adds when
  // negative; in CORRECT it always adds M back onto A.
  always_comb begin
    as_a   = shift_a;
    as_sub = ~a_reg[AW-1];
    if (state == CORRECT) begin
      as_a   = a_reg;
      as_sub = 1'b0;
    end
  end

  nr_addsub #(
    .WIDTH (AW)
  ) u_addsub (
    .a   (as_a),
    .b   (m_reg),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = div_zero_in ? FINISH : ITER;
      end
      ITER: begin
        if (cnt == CNT_W'(1)) state_nxt = CORRECT;
      end
      CORRECT: state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            dz_pend     <= div_zero_in;
            cnt         <= CNT_W'(WIDTH);
          end
        end
        ITER: begin
          cnt <= cnt - CNT_W'(1);
        end
        CORRECT: begin
          quotient  <= q_reg;
          remainder <= a_reg[AW-1] ? as_sum[WIDTH-1:0] : a_reg[WIDTH-1:0];
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          // Divide-by-zero skips ITER, so q_reg still holds the dividend.
          if (dz_pend) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= q_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          a_reg <= '0;
          q_reg <= dividend;
          m_reg <= $signed({1'b0, divisor});
        end
      end
      ITER: begin
        a_reg <= as_sum;
        q_reg <= {q_reg[WIDTH-2:0], ~as_sum[AW-1]};
      end
      default: ;
    endcase
  end

endmodule
